// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory sequencer shared by instruction fetch and
// load/store. Round-robin grant, registered request/ack handshake,
// read-modify-write for byte/halfword stores, misaligned data access flagging.
module mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_ack,
  output logic [31:0]           if_data,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [31:0]           d_write_data,
  output logic                  d_ack,
  output logic [31:0]           d_read_data,
  output logic                  d_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write,
  input  logic [31:0]           mem_read_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR       = 3'd2,
    RMW_WAIT = 3'd3,
    RMW_WR   = 3'd4,
    ERR      = 3'd5
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t                state;
  state_t                next_state;
  logic                  last_grant;     // 1 = data port was granted last
  logic                  owner_data;     // current transaction belongs to data port
  logic [2:0]            wait_cnt;
  logic [1:0]            lat_size;
  logic [1:0]            lat_offset;
  logic [31:0]           lat_wdata;
  logic [31:0]           if_data_hold;
  logic [31:0]           d_read_data_hold;
  logic [ADDR_WIDTH-1:0] mem_address_reg;
  logic [31:0]           mem_write_data_reg;
  logic                  grant_if;
  logic                  grant_d;
  logic                  d_misaligned;
  logic                  read_done;
  logic                  load_done;
  logic                  unused_if_offset;

  // Fetch addresses are word-aligned by the fetch unit; low bits are ignored.
  assign unused_if_offset = ^if_address[1:0];

  // Halfwords need an even address, words a word-aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = offset[0];
      default: bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

  // Replace only the addressed big-endian lane of the read word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] rd, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] offset);
    logic [31:0] merged;
    if (size == 2'b00) begin
      case (offset)
        2'b00:   merged = {wd[7:0], rd[23:0]};
        2'b01:   merged = {rd[31:24], wd[7:0], rd[15:0]};
        2'b10:   merged = {rd[31:16], wd[7:0], rd[7:0]};
        default: merged = {rd[31:8], wd[7:0]};
      endcase
    end else if (size == 2'b01) begin
      merged = offset[1] ? {rd[31:16], wd[15:0]} : {wd[15:0], rd[15:0]};
    end else begin
      merged = rd;
    end
    return merged;
  endfunction

  // Grant decision in IDLE: a lone requester wins, a conflict goes to the one not served last.
  always_comb begin
    grant_if     = 1'b0;
    grant_d      = 1'b0;
    d_misaligned = is_misaligned(d_size, d_address[1:0]);
    if (state == IDLE) begin
      if (if_req && d_req) begin
        grant_d  = ~last_grant;
        grant_if = last_grant;
      end else begin
        grant_d  = d_req;
        grant_if = if_req;
      end
    end else begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    next_state = state;
    read_done  = ((state == RD_WAIT) || (state == RMW_WAIT)) && (wait_cnt == 3'd0);
    case (state)
      IDLE: begin
        if (grant_d) begin
          if (d_misaligned)    next_state = ERR;
          else if (!d_write)   next_state = RD_WAIT;
          else if (d_size[1])  next_state = WR;
          else                 next_state = RMW_WAIT;
        end else if (grant_if) begin
          next_state = RD_WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      RD_WAIT: begin
        if (read_done) next_state = IDLE;
        else           next_state = RD_WAIT;
      end
      RMW_WAIT: begin
        if (read_done) next_state = RMW_WR;
        else           next_state = RMW_WAIT;
      end
      WR, RMW_WR, ERR: next_state = IDLE;
      default:         next_state = IDLE;
    endcase
  end

  // State register, grant bookkeeping, wait counter and data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      last_grant         <= 1'b0;
      owner_data         <= 1'b0;
      wait_cnt           <= 3'd0;
      lat_size           <= 2'b00;
      lat_offset         <= 2'b00;
      lat_wdata          <= 32'd0;
      if_data_hold       <= 32'd0;
      d_read_data_hold   <= 32'd0;
      mem_address_reg    <= '0;
      mem_write_data_reg <= 32'd0;
    end else begin
      state <= next_state;
      if (grant_d || grant_if) begin
        last_grant <= grant_d;
        owner_data <= grant_d;
        wait_cnt   <= LAT;
        if (grant_d) begin
          lat_size   <= d_size;
          lat_offset <= d_address[1:0];
          lat_wdata  <= d_write_data;
          if (!d_misaligned) begin
            mem_address_reg <= {d_address[ADDR_WIDTH-1:2], 2'b00};
            if (d_write) mem_write_data_reg <= d_write_data;
          end
        end else begin
          lat_size        <= 2'b10;
          lat_offset      <= 2'b00;
          mem_address_reg <= {if_address[ADDR_WIDTH-1:2], 2'b00};
        end
      end else if (wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (read_done) begin
        if (state == RMW_WAIT) begin
          mem_write_data_reg <= merge_lane(mem_read_data, lat_wdata, lat_size, lat_offset);
        end else if (owner_data) begin
          d_read_data_hold <= mem_read_data;
        end else begin
          if_data_hold <= mem_read_data;
        end
      end
    end
  end

  // Output decode from the registered state; read data passes through on the capture cycle.
  always_comb begin
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    d_error   = 1'b0;
    mem_write = 1'b0;
    load_done = 1'b0;
    case (state)
      RD_WAIT: begin
        if (wait_cnt == 3'd0) begin
          if (owner_data) begin
            d_ack     = 1'b1;
            load_done = 1'b1;
          end else begin
            if_ack = 1'b1;
          end
        end else begin
          if_ack = 1'b0;
        end
      end
      WR, RMW_WR: begin
        mem_write = 1'b1;
        d_ack     = 1'b1;
      end
      ERR: begin
        d_ack   = 1'b1;
        d_error = 1'b1;
      end
      default: begin
        if_ack = 1'b0;
      end
    endcase
    busy           = (state != IDLE);
    if_data        = if_ack ? mem_read_data : if_data_hold;
    d_read_data    = load_done ? mem_read_data : d_read_data_hold;
    mem_address    = mem_address_reg;
    mem_write_data = mem_write_data_reg;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: expected acks/writes are queued when
// stimulus is driven and compared by a monitor when the DUT responds.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_address;
  logic        if_ack;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_address;
  logic [31:0] d_write_data;
  logic        d_ack;
  logic [31:0] d_read_data;
  logic        d_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic        busy;

  mem_arbiter #(.READ_LATENCY(1), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_address(if_address), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_address(d_address),
    .d_write_data(d_write_data), .d_ack(d_ack), .d_read_data(d_read_data), .d_error(d_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic chk; logic [31:0] data; } d_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;

  logic [31:0] if_q[$];
  d_exp_t      d_q[$];
  wr_exp_t     wr_q[$];
  logic [7:0]  ack_log[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;

  // Memory model: synchronous read (latency 1), bench preload port, DUT writes.
  logic [31:0] mem [0:511];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = 32'd0;
  logic [31:0] pre_data = 32'd0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr[10:2]] <= pre_data;
    else if (mem_write) mem[mem_address[10:2]] <= mem_write_data;
    mem_read_data <= mem[mem_address[10:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation for every ack and every write.
  initial begin
    d_exp_t  de;
    wr_exp_t we;
    logic [31:0] ie;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (if_ack) begin
          ack_log.push_back(8'h49);
          if (if_q.size() == 0) check_eq("if_ack_unexpected", 32'd1, 32'd0);
          else begin ie = if_q.pop_front(); check_eq("if_data", if_data, ie); end
        end
        if (d_ack) begin
          ack_log.push_back(8'h44);
          if (d_q.size() == 0) check_eq("d_ack_unexpected", 32'd1, 32'd0);
          else begin
            de = d_q.pop_front();
            check_eq("d_error", {31'd0, d_error}, {31'd0, de.err});
            if (de.chk) check_eq("d_read_data", d_read_data, de.data);
          end
        end else if (d_error) begin
          check_eq("d_error_without_ack", 32'd1, 32'd0);
        end
        if (mem_write) begin
          wr_count++;
          check_eq("write_with_d_ack", {31'd0, d_ack}, 32'd1);
          if (wr_q.size() == 0) check_eq("write_unexpected", 32'd1, 32'd0);
          else begin
            we = wr_q.pop_front();
            check_eq("write_addr", mem_address, we.addr);
            check_eq("write_data", mem_write_data, we.data);
          end
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    pre_addr = a; pre_data = v; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic push_d(input logic err, input logic chk, input logic [31:0] v);
    d_exp_t e;
    e.err = err; e.chk = chk; e.data = v;
    d_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] v);
    wr_exp_t e;
    e.addr = a; e.data = v;
    wr_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_acks"}, {29'd0, if_ack, d_ack, d_error}, 32'd0);
    check_eq({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check_eq({tag, "_mem_address"}, mem_address, 32'd0);
    check_eq({tag, "_mem_write_data"}, mem_write_data, 32'd0);
    check_eq({tag, "_if_data"}, if_data, 32'd0);
    check_eq({tag, "_d_read_data"}, d_read_data, 32'd0);
  endtask

  // Fetch of 0x100 with exact cycle-by-cycle timing (mem holds 0x2402000A).
  task automatic fetch_basic(input string tag);
    if_q.push_back(32'h2402000A);
    if_address = 32'h100; if_req = 1'b1;
    @(negedge clk);
    check_eq({tag, "_g1_mem_address"}, mem_address, 32'h100);
    check_eq({tag, "_g1_busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_g1_if_ack"}, {31'd0, if_ack}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_g2_if_ack"}, {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check_eq({tag, "_g3_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_g3_if_ack"}, {31'd0, if_ack}, 32'd0);
    check_eq({tag, "_g3_if_data_held"}, if_data, 32'h2402000A);
  endtask

  // One data transaction; checks cycles from grant to d_ack and the write count.
  task automatic run_d(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_lat, input int exp_writes,
                       input string tag);
    int n = 0;
    int w0 = wr_count;
    logic done = 1'b0;
    d_write = wr; d_size = sz; d_address = a; d_write_data = wd; d_req = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (d_ack) done = 1'b1;
    end
    check_eq({tag, "_ack_seen"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_latency"}, n, exp_lat);
    d_req = 1'b0;
    @(negedge clk);
    #1;
    check_eq({tag, "_write_count"}, wr_count - w0, exp_writes);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    logic [7:0] exp_order [4];
    exp_order[0] = 8'h44; exp_order[1] = 8'h49; exp_order[2] = 8'h44; exp_order[3] = 8'h49;
    reset = 1'b1; if_req = 1'b0; if_address = 32'd0;
    d_req = 1'b0; d_write = 1'b0; d_size = 2'b10; d_address = 32'd0; d_write_data = 32'd0;
    preload(32'h100, 32'h2402000A);
    preload(32'h104, 32'h00000013);
    preload(32'h200, 32'h55AA00FF);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Scenario 1: basic fetch timing.
    fetch_basic("fetch1");

    // Scenario 2: both requesters from reset; data first, then strict alternation.
    reset = 1'b1;
    if_address = 32'h104; if_req = 1'b1;
    d_write = 1'b0; d_size = 2'b10; d_address = 32'h200; d_req = 1'b1;
    if_q.push_back(32'h00000013); if_q.push_back(32'h00000013);
    push_d(1'b0, 1'b1, 32'h55AA00FF); push_d(1'b0, 1'b1, 32'h55AA00FF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack_log.delete();
    n = 0;
    while (ack_log.size() < 4 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if_req = 1'b0; d_req = 1'b0;
    check_eq("fair_ack_count", ack_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("fair_order_%0d", i), ack_log[i], exp_order[i]);
    @(negedge clk);

    // Scenario 3: byte store via read-modify-write.
    preload(32'h200, 32'h11223344);
    push_wr(32'h200, 32'h112233AB); push_d(1'b0, 1'b0, 32'd0);
    run_d(1'b1, 2'b00, 32'h203, 32'h000000AB, 3, 1, "sb_203");

    // Scenario 4: halfword RMW, word store, readback; then every lane position.
    preload(32'h300, 32'h01020304);
    push_wr(32'h300, 32'hBEEF0304); push_d(1'b0, 1'b0, 32'd0);
    run_d(1'b1, 2'b01, 32'h300, 32'h0000BEEF, 3, 1, "sh_300");
    push_wr(32'h304, 32'hCAFEF00D); push_d(1'b0, 1'b0, 32'd0);
    run_d(1'b1, 2'b10, 32'h304, 32'hCAFEF00D, 1, 1, "sw_304");
    push_d(1'b0, 1'b1, 32'hBEEF0304);
    run_d(1'b0, 2'b10, 32'h300, 32'd0, 2, 0, "lw_300");
    push_d(1'b0, 1'b1, 32'hCAFEF00D);
    run_d(1'b0, 2'b11, 32'h304, 32'd0, 2, 0, "lw_304_size3");
    preload(32'h400, 32'hA1B2C3D4);
    push_wr(32'h400, 32'h5AB2C3D4); push_d(1'b0, 1'b0, 32'd0);
    run_d(1'b1, 2'b00, 32'h400, 32'hFFFFFF5A, 3, 1, "sb_400");
    push_wr(32'h400, 32'h5AB21234); push_d(1'b0, 1'b0, 32'd0);
    run_d(1'b1, 2'b01, 32'h402, 32'hFFFF1234, 3, 1, "sh_402");
    push_wr(32'h400, 32'h5A771234); push_d(1'b0, 1'b0, 32'd0);
    run_d(1'b1, 2'b00, 32'h401, 32'h12345677, 3, 1, "sb_401");
    push_wr(32'h400, 32'h5A779934); push_d(1'b0, 1'b0, 32'd0);
    run_d(1'b1, 2'b00, 32'h402, 32'h00000099, 3, 1, "sb_402");
    push_d(1'b0, 1'b1, 32'h5A779934);
    run_d(1'b0, 2'b01, 32'h402, 32'd0, 2, 0, "lh_402");

    // Scenario 5: misaligned accesses answer at G+1 with no memory write.
    push_d(1'b1, 1'b0, 32'd0);
    run_d(1'b1, 2'b01, 32'h301, 32'h0000BEEF, 1, 0, "sh_301_err");
    push_d(1'b1, 1'b0, 32'd0);
    run_d(1'b0, 2'b10, 32'h302, 32'd0, 1, 0, "lw_302_err");
    push_d(1'b1, 1'b0, 32'd0);
    run_d(1'b1, 2'b10, 32'h306, 32'h12345678, 1, 0, "sw_306_err");

    // Scenario 6: reset during RMW_WAIT abandons the store.
    preload(32'h500, 32'hDEADBEEF);
    w0 = wr_count;
    d_write = 1'b1; d_size = 2'b00; d_address = 32'h501; d_write_data = 32'h11; d_req = 1'b1;
    @(negedge clk);
    check_eq("rmw_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check_idle("reset_mid");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("reset_mid_no_write", wr_count - w0, 32'd0);
    fetch_basic("fetch2");

    repeat (2) @(negedge clk);
    check_eq("if_q_drained", if_q.size(), 32'd0);
    check_eq("d_q_drained", d_q.size(), 32'd0);
    check_eq("wr_q_drained", wr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
